// File: rtl/gpr_pkg.sv
// Shared constants and FSM state encoding for the general-purpose register file.
package gpr_pkg;

   localparam int GPR_ADDR_W = 5;
   localparam int GPR_DATA_W = 32;

   localparam logic [GPR_ADDR_W-1:0] GPR_ZERO = 5'd0;
   localparam logic [GPR_ADDR_W-1:0] GPR_LAST = 5'd31;

   typedef logic [0:0] gpr_state_t;
   localparam gpr_state_t GPR_CLEAR = 1'b0;
   localparam gpr_state_t GPR_READY = 1'b1;

endpackage

// File: rtl/gpr_file_if.sv
// Writeback bus from the MEM/WB stage into the register file.
interface gpr_file_if #(
   parameter int ADDR_W = gpr_pkg::GPR_ADDR_W,
   parameter int DATA_W = gpr_pkg::GPR_DATA_W
);
   logic              wb_GPR_we;
   logic [ADDR_W-1:0] wb_GPR_waddr;
   logic [DATA_W-1:0] wb_GPR_wdata;

   modport master (output wb_GPR_we, output wb_GPR_waddr, output wb_GPR_wdata);
   modport slave  (input  wb_GPR_we, input  wb_GPR_waddr, input  wb_GPR_wdata);
endinterface

// File: rtl/gpr_clear_seq.sv
// Post-reset clear sequencer: walks GPR1..GPR(NUM_REGS-1) writing zero, one per cycle.
module gpr_clear_seq
   import gpr_pkg::*;
#(
   parameter int ADDR_W   = GPR_ADDR_W,
   parameter int NUM_REGS = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              init_busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   gpr_state_t        state;
   logic [ADDR_W-1:0] clr_ptr;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= GPR_CLEAR;
         clr_ptr <= ADDR_W'(1);
      end else if (state == GPR_CLEAR) begin
         clr_ptr <= clr_ptr + ADDR_W'(1);
         if (clr_ptr == LAST_ADDR) state <= GPR_READY;
      end
   end

   assign init_busy = (state == GPR_CLEAR);
   assign clr_we    = init_busy;
   assign clr_addr  = clr_ptr;

endmodule

// File: rtl/gpr_file.sv
// Register file with two ID read ports, a debug port and a post-reset clear sequence.
// Optional write-through bypass on the ID ports: define GPR_WB_FWD_EN.
module gpr_file
   import gpr_pkg::*;
#(
   parameter int DATA_W   = GPR_DATA_W,
   parameter int ADDR_W   = GPR_ADDR_W,
   parameter int NUM_REGS = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   gpr_file_if.slave         wb,
   input  logic [ADDR_W-1:0] id_rs_addr,
   input  logic [ADDR_W-1:0] id_rt_addr,
   output logic [DATA_W-1:0] id_rs_data,
   output logic [DATA_W-1:0] id_rt_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              init_busy,
   output logic [31:0]       wb_write_cnt
);

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wb_commit;
   logic              arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdata;
   logic [31:0]       wb_cnt_q;
   logic [DATA_W-1:0] regs [NUM_REGS];

   gpr_clear_seq #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_clear_seq (
      .clk       (clk),
      .reset     (reset),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .init_busy (init_busy)
   );

   assign wb_commit = !reset && !init_busy && wb.wb_GPR_we && (wb.wb_GPR_waddr != '0);

   // The clear sequencer owns the write port for as long as it runs.
   assign arr_we    = !reset && (clr_we || wb_commit);
   assign arr_addr  = clr_we ? clr_addr : wb.wb_GPR_waddr;
   assign arr_wdata = clr_we ? '0 : wb.wb_GPR_wdata;

   // NOTE: no reset on the array so it maps to LUTRAM; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (arr_we) regs[arr_addr] <= arr_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)          wb_cnt_q <= '0;
      else if (wb_commit) wb_cnt_q <= wb_cnt_q + 32'd1;
   end

   assign wb_write_cnt = wb_cnt_q;

`ifdef GPR_WB_FWD_EN
   logic fwd_ok;
   assign fwd_ok = !init_busy && wb.wb_GPR_we && (wb.wb_GPR_waddr != '0);
`endif

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      id_rs_data = '0;
      id_rt_data = '0;
      dbg_data   = '0;
      if (!init_busy) begin
         if (id_rs_addr != '0) id_rs_data = regs[id_rs_addr];
         if (id_rt_addr != '0) id_rt_data = regs[id_rt_addr];
         if (dbg_addr   != '0) dbg_data   = regs[dbg_addr];
`ifdef GPR_WB_FWD_EN
         if (fwd_ok && (wb.wb_GPR_waddr == id_rs_addr)) id_rs_data = wb.wb_GPR_wdata;
         if (fwd_ok && (wb.wb_GPR_waddr == id_rt_addr)) id_rt_data = wb.wb_GPR_wdata;
`endif
      end
   end

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: table-driven READY vectors plus clear/reset/wrap sequences.
module tb_gpr_file;
   import gpr_pkg::*;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  dbg_addr;
      logic [31:0] exp_rs;
      logic [31:0] exp_rt;
      logic [31:0] exp_dbg;
      logic [31:0] exp_cnt;
   } vec_t;

   localparam int NV = 11;

`ifdef GPR_WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs_addr, id_rt_addr, dbg_addr;
   logic [31:0] id_rs_data, id_rt_data, dbg_data;
   logic        init_busy;
   logic [31:0] wb_write_cnt;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs [NV];

   gpr_file_if wb_if ();

   gpr_file dut (
      .clk          (clk),
      .reset        (reset),
      .wb           (wb_if.slave),
      .id_rs_addr   (id_rs_addr),
      .id_rt_addr   (id_rt_addr),
      .id_rs_data   (id_rs_data),
      .id_rt_data   (id_rt_data),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .init_busy    (init_busy),
      .wb_write_cnt (wb_write_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_drive(input logic we, input logic [4:0] a, input logic [31:0] d);
      wb_if.wb_GPR_we    = we;
      wb_if.wb_GPR_waddr = a;
      wb_if.wb_GPR_wdata = d;
   endtask

   // Ticks until init_busy drops (bounded) and returns the number of edges taken.
   task automatic count_clear(output int n);
      n = 0;
      while (init_busy && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;

      //           we  waddr  wdata          rs  rt  dbg  exp_rs                        exp_rt                  exp_dbg        cnt
      vecs[0]  = '{1, 5'd5,  32'hDEADBEEF, 5, 0,  5,  FWD ? 32'hDEADBEEF : 32'h0,   32'h0,                  32'h0,         1};
      vecs[1]  = '{0, 5'd0,  32'h0,        5, 5,  5,  32'hDEADBEEF,                 32'hDEADBEEF,           32'hDEADBEEF,  1};
      vecs[2]  = '{1, 5'd0,  32'h1234,     0, 0,  0,  32'h0,                        32'h0,                  32'h0,         1};
      vecs[3]  = '{0, 5'd0,  32'h0,        0, 0,  0,  32'h0,                        32'h0,                  32'h0,         1};
      vecs[4]  = '{1, 5'd7,  32'h11,       5, 6,  7,  32'hDEADBEEF,                 32'h0,                  32'h0,         2};
      vecs[5]  = '{1, 5'd7,  32'hA5A5A5A5, 7, 7,  7,  FWD ? 32'hA5A5A5A5 : 32'h11,  FWD ? 32'hA5A5A5A5 : 32'h11, 32'h11,  3};
      vecs[6]  = '{0, 5'd0,  32'h0,        7, 5,  7,  32'hA5A5A5A5,                 32'hDEADBEEF,           32'hA5A5A5A5,  3};
      vecs[7]  = '{1, 5'd31, 32'h80000000, 31, 1, 31, FWD ? 32'h80000000 : 32'h0,  32'h0,                  32'h0,         4};
      vecs[8]  = '{0, 5'd0,  32'h0,        31, 31, 31, 32'h80000000,                32'h80000000,           32'h80000000,  4};
      vecs[9]  = '{1, 5'd1,  32'h1,        2, 1,  1,  32'h0,                        FWD ? 32'h1 : 32'h0,    32'h0,         5};
      vecs[10] = '{0, 5'd0,  32'h0,        1, 2,  0,  32'h1,                        32'h0,                  32'h0,         5};

      reset = 1'b1;
      wb_drive(1'b0, 5'd0, 32'h0);
      id_rs_addr = 5'd0;
      id_rt_addr = 5'd0;
      dbg_addr   = 5'd0;
      repeat (3) tick();
      check("reset_busy", 32'(init_busy), 32'd1);
      check("reset_cnt", wb_write_cnt, 32'd0);

      reset = 1'b0;
      count_clear(n);
      check("clear_len", n, 32'd31);
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1;
         check($sformatf("clear_dbg%0d", a), dbg_data, 32'h0);
      end
      check("ready_cnt", wb_write_cnt, 32'd0);

      for (int i = 0; i < NV; i++) begin
         wb_drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata);
         id_rs_addr = vecs[i].rs_addr;
         id_rt_addr = vecs[i].rt_addr;
         dbg_addr   = vecs[i].dbg_addr;
         #1;
         check($sformatf("v%0d_rs", i),  id_rs_data, vecs[i].exp_rs);
         check($sformatf("v%0d_rt", i),  id_rt_data, vecs[i].exp_rt);
         check($sformatf("v%0d_dbg", i), dbg_data,   vecs[i].exp_dbg);
         tick();
         check($sformatf("v%0d_cnt", i), wb_write_cnt, vecs[i].exp_cnt);
      end
      wb_drive(1'b0, 5'd0, 32'h0);

      // Reset from READY: stored data is masked immediately, then re-zeroed by the sequence.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      id_rs_addr = 5'd5;
      id_rt_addr = 5'd31;
      dbg_addr   = 5'd7;
      #1;
      check("clr_rs_mask",  id_rs_data, 32'h0);
      check("clr_rt_mask",  id_rt_data, 32'h0);
      check("clr_dbg_mask", dbg_data,   32'h0);
      check("clr_busy",     32'(init_busy), 32'd1);
      check("clr_cnt_rst",  wb_write_cnt, 32'd0);

      // Reset at clear edge 10 restarts the sequence; a stray WB write late in CLEAR is dropped.
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (20) tick();
      wb_drive(1'b1, 5'd3, 32'hFF);
      tick();
      wb_drive(1'b0, 5'd0, 32'h0);
      count_clear(n);
      check("restart_len", n + 21, 32'd31);
      dbg_addr = 5'd3;
      #1;
      check("clr_wb_ignored", dbg_data, 32'h0);
      check("clr_wb_cnt", wb_write_cnt, 32'd0);
      dbg_addr = 5'd31;
      #1;
      check("gpr31_cleared", dbg_data, 32'h0);
      dbg_addr = 5'd5;
      #1;
      check("gpr5_cleared", dbg_data, 32'h0);

      // Counter wrap from a preloaded value.
      force dut.wb_cnt_q = 32'hFFFFFFFE;
      #1;
      release dut.wb_cnt_q;
      wb_drive(1'b1, 5'd2, 32'h22);
      tick();
      check("wrap_ff", wb_write_cnt, 32'hFFFFFFFF);
      wb_drive(1'b1, 5'd0, 32'h33);
      tick();
      check("wrap_zero_addr", wb_write_cnt, 32'hFFFFFFFF);
      wb_drive(1'b1, 5'd4, 32'h44);
      tick();
      check("wrap_00", wb_write_cnt, 32'h00000000);
      wb_drive(1'b0, 5'd0, 32'h0);
      id_rs_addr = 5'd2;
      id_rt_addr = 5'd4;
      #1;
      check("wrap_gpr2", id_rs_data, 32'h22);
      check("wrap_gpr4", id_rt_data, 32'h44);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
